// File: rtl/decoder_rr_arbiter_pkg.sv
// rtl/decoder_rr_arbiter_pkg.sv - shared types and helpers for the decoder round-robin arbiter
package decoder_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/decoder_rr_arbiter_rr_pick4.sv
// rtl/decoder_rr_arbiter_rr_pick4.sv - combinational rotating-priority pick among four requesters
module rr_pick4
  import decoder_rr_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] win,
  output logic       any
);

  logic [1:0] cand;

  // Walk offsets from farthest (ptr itself) to nearest (ptr+1); the last hit is the nearest set bit.
  always_comb begin
    win  = ptr;
    cand = ptr;
    any  = |req;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) win = cand;
    end
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// rtl/decoder_rr_arbiter.sv - round-robin owner selection driving a 2-to-4 decoder with hold limit and dead gap
module decoder_rr_arbiter
  import decoder_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic       addr0,
  output logic       addr1,
  output logic       enable,
  output logic       preempt,
  output logic       busy
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  // With no limit the counter just parks at all-ones instead of wrapping.
  localparam logic [HOLD_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? '1 : HOLD_MAX;

  state_t            state, state_nx;
  logic [1:0]        ptr, ptr_nx;
  logic [1:0]        addr_q, addr_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_nx;
  logic              en_nx, pre_nx;
  logic [1:0]        win;
  logic              any;
  logic              limit_hit;
  logic              others;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  assign limit_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX);
  assign others    = |(req & ~onehot4(ptr));
  assign addr0     = addr_q[0];
  assign addr1     = addr_q[1];

  // Next-state and next-output decisions; owner drop outranks timeout so a drop never pulses preempt.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    addr_nx  = addr_q;
    hold_nx  = hold_cnt;
    en_nx    = 1'b0;
    pre_nx   = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (any) begin
          state_nx = BUSY;
          ptr_nx   = win;
          addr_nx  = win;
          hold_nx  = HOLD_W'(1);
          en_nx    = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      BUSY: begin
        if (!req[ptr]) begin
          state_nx = GAP;
        end else if (limit_hit && others) begin
          state_nx = GAP;
          pre_nx   = 1'b1;
        end else begin
          en_nx = 1'b1;
          if (hold_cnt != HOLD_SAT) hold_nx = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, pointer, counter and decoder-facing output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= 2'd3;
      addr_q   <= 2'd0;
      hold_cnt <= '0;
      enable   <= 1'b0;
      preempt  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      addr_q   <= addr_nx;
      hold_cnt <= hold_nx;
      enable   <= en_nx;
      preempt  <= pre_nx;
      busy     <= (state_nx == BUSY);
    end
  end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// tb/tb_decoder_rr_arbiter.sv - randomized and directed self-checking bench for decoder_rr_arbiter
module tb_decoder_rr_arbiter;

  logic       clk = 1'b0;
  logic       rsta, rstb;
  logic [3:0] ra, rb;
  logic       a0a, a1a, ena, prea, busa;
  logic       a0b, a1b, enb, preb, busb;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  // behavioural model state, one slot per DUT instance
  int mh[2] = '{4, 0};
  int m_own[2];
  int m_last[2];
  int m_held[2];
  int m_addr[2];
  bit m_pre[2];
  bit p_en[2];
  logic [1:0] p_ad[2];

  always #5 clk = ~clk;

  decoder_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(8)) dut_a (
    .clk(clk), .reset(rsta), .req(ra),
    .addr0(a0a), .addr1(a1a), .enable(ena), .preempt(prea), .busy(busa)
  );

  decoder_rr_arbiter #(.MAX_HOLD(0), .HOLD_W(8)) dut_b (
    .clk(clk), .reset(rstb), .req(rb),
    .addr0(a0b), .addr1(a1b), .enable(enb), .preempt(preb), .busy(busb)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input logic rs, input logic [3:0] r);
    bit others;
    int c;
    if (rs) begin
      m_own[k] = -1; m_last[k] = 3; m_held[k] = 0; m_pre[k] = 0; m_addr[k] = 0;
    end else if (m_own[k] >= 0) begin
      others = (r & ~(4'b0001 << m_own[k])) != 4'b0000;
      if (!r[m_own[k]]) begin
        m_own[k] = -1; m_pre[k] = 0;
      end else if (mh[k] != 0 && m_held[k] >= mh[k] && others) begin
        m_own[k] = -1; m_pre[k] = 1;
      end else begin
        m_held[k]++;
      end
    end else begin
      m_pre[k] = 0;
      for (int i = 1; i <= 4; i++) begin
        c = (m_last[k] + i) % 4;
        if (m_own[k] < 0 && r[c]) begin
          m_own[k] = c; m_last[k] = c; m_addr[k] = c; m_held[k] = 1;
        end
      end
    end
  endtask

  // advance the model on the same edge the DUTs see
  always @(posedge clk) begin
    model_step(0, rsta, ra);
    model_step(1, rstb, rb);
    if (rsta && rstb) cmp_on = 1'b1;
  end

  task automatic cmp_inst(input int k, input logic en, input logic [1:0] ad, input logic pr, input logic bz);
    check($sformatf("m%0d.enable", k), 8'(en), 8'(m_own[k] >= 0));
    check($sformatf("m%0d.addr", k), 8'(ad), 8'(m_addr[k]));
    check($sformatf("m%0d.preempt", k), 8'(pr), 8'(m_pre[k]));
    check($sformatf("m%0d.busy", k), 8'(bz), 8'(m_own[k] >= 0));
    if (en && p_en[k]) check($sformatf("m%0d.no_back_to_back_owner", k), 8'(ad), 8'(p_ad[k]));
    p_en[k] = en;
    p_ad[k] = ad;
  endtask

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_on) begin
      cmp_inst(0, ena, {a1a, a0a}, prea, busa);
      cmp_inst(1, enb, {a1b, a0b}, preb, busb);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_a(input string name, input logic en, input logic [1:0] ad, input logic pr);
    check({name, ".en"}, 8'(ena), 8'(en));
    check({name, ".addr"}, 8'({a1a, a0a}), 8'(ad));
    check({name, ".pre"}, 8'(prea), 8'(pr));
  endtask

  task automatic expect_b(input string name, input logic en, input logic [1:0] ad, input logic pr);
    check({name, ".en"}, 8'(enb), 8'(en));
    check({name, ".addr"}, 8'({a1b, a0b}), 8'(ad));
    check({name, ".pre"}, 8'(preb), 8'(pr));
  endtask

  initial begin
    rsta = 1'b1; rstb = 1'b1; ra = 4'b1111; rb = 4'b0000;

    // reset held two cycles with all requests raised
    tick(); expect_a("reset1", 1'b0, 2'd0, 1'b0);
    tick(); expect_a("reset2", 1'b0, 2'd0, 1'b0);

    // timeout rotation: four enable cycles per owner, then a preempt gap
    rsta = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (c % 5 == 4) expect_a($sformatf("rot%0d", c), 1'b0, 2'((c / 5) % 4), 1'b1);
      else            expect_a($sformatf("rot%0d", c), 1'b1, 2'((c / 5) % 4), 1'b0);
    end

    // single requester holding then releasing
    rsta = 1'b1; ra = 4'b0000; tick();
    rsta = 1'b0; ra = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick(); expect_a($sformatf("single%0d", i), 1'b1, 2'd2, 1'b0);
    end
    ra = 4'b0000;
    tick(); expect_a("single_gap", 1'b0, 2'd2, 1'b0);
    tick(); expect_a("single_idle", 1'b0, 2'd2, 1'b0);

    // release ordering on the unlimited instance
    rstb = 1'b0; rb = 4'b0010;
    tick(); expect_b("ord_own1", 1'b1, 2'd1, 1'b0);
    rb = 4'b1011;
    tick(); tick(); expect_b("ord_still1", 1'b1, 2'd1, 1'b0);
    rb = 4'b1001;
    tick(); expect_b("ord_gap1", 1'b0, 2'd1, 1'b0);
    tick(); expect_b("ord_own3", 1'b1, 2'd3, 1'b0);
    rb = 4'b0001;
    tick(); expect_b("ord_gap2", 1'b0, 2'd3, 1'b0);
    tick(); expect_b("ord_own0", 1'b1, 2'd0, 1'b0);

    // unlimited hold with a waiting requester
    rb = 4'b0011;
    for (int i = 0; i < 100; i++) begin
      tick(); expect_b($sformatf("unl%0d", i), 1'b1, 2'd0, 1'b0);
    end
    rb = 4'b0010;
    tick(); expect_b("unl_gap", 1'b0, 2'd0, 1'b0);
    tick(); expect_b("unl_own1", 1'b1, 2'd1, 1'b0);

    // reset in the middle of a grant
    ra = 4'b0100;
    tick(); expect_a("mid_own2", 1'b1, 2'd2, 1'b0);
    tick();
    rsta = 1'b1;
    tick(); expect_a("mid_reset", 1'b0, 2'd0, 1'b0);
    rsta = 1'b0;
    tick(); expect_a("mid_regrant", 1'b1, 2'd2, 1'b0);

    // randomized traffic with occasional resets, checked by the model each cycle
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) ra[b] = ~ra[b];
        if ($urandom_range(0, 5) == 0) rb[b] = ~rb[b];
      end
      rsta = ($urandom_range(0, 299) == 0);
      rstb = ($urandom_range(0, 299) == 0);
      tick();
    end

    rsta = 1'b0; rstb = 1'b0; ra = 4'b0000; rb = 4'b0000;
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_rr_arbiter.md
Name: decoder_rr_arbiter

Overview:
- Round-robin arbiter that shares the 2-to-4 decoder (addr0, addr1, enable inputs) among four requesters.
- Its registered addr0/addr1/enable drive the decoder directly, so decoder out0..out3 form the one-hot grant to requesters 0..3.
- Adds a hold-time limit with preemption and a one-cycle dead gap between owners, so two decoder outputs are never high on consecutive cycles.

Parameters:
- MAX_HOLD, 16, maximum consecutive enable cycles per grant while others wait; 0 = unlimited.
- HOLD_W, 8, hold counter width; MAX_HOLD must be < 2^HOLD_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request per requester; bit i = requester i; level, held for the whole transaction.
- addr0  output  1  decoder address LSB (owner index bit 0), registered.
- addr1  output  1  decoder address MSB (owner index bit 1), registered.
- enable  output  1  decoder enable; high only while an owner holds the grant, registered.
- preempt  output  1  one-cycle pulse when a grant ends by timeout.
- busy  output  1  high in BUSY state.

Behaviour:
- Reset (sampled at clk edge with reset=1):
  - state=IDLE, enable=0, addr1:addr0=00, preempt=0, busy=0.
  - ptr=3, so requester 0 has first priority; hold_cnt=0.
  - reset overrides everything; asserting it mid-grant drops enable at that same edge.
- Arbitration pick (combinational):
  - Scan req cyclically starting at ptr+1 (mod 4); first set bit wins.
  - The last owner (ptr) has the lowest priority.
- IDLE:
  - req==0000: stay; enable=0, addr holds its last value.
  - Any req set: next edge go to BUSY with enable=1, addr=winner, ptr=winner, hold_cnt=1, busy=1.
  - Latency: req high before edge n gives enable=1 after edge n.
- BUSY, priority order:
  - (a) req[ptr]==0: go to GAP.
  - (b) MAX_HOLD!=0 and hold_cnt==MAX_HOLD and (req & ~onehot(ptr))!=0: go to GAP; preempt=1 for that one cycle.
  - (c) Otherwise stay; hold_cnt increments, saturating at MAX_HOLD (no wrap).
  - Owner alone at the limit keeps the grant indefinitely, with no preempt.
- GAP (exactly one cycle):
  - enable=0, busy=0, addr holds the previous owner.
  - Next edge: if any req, arbitrate as in IDLE and go to BUSY (the preempted owner, if still requesting, is lowest priority); else go to IDLE.
- Simultaneous events:
  - Owner drop and timeout on the same cycle: treat as drop; preempt=0.
  - New reqs arriving during BUSY are ignored until GAP/IDLE.
- Invariants:
  - enable never high on two cycles with different addr values without an intervening enable=0 cycle.
  - addr changes only on an edge entering BUSY.

Decomposition:
- Shared header (decoder_arb_defs.vh):
  - State encodings IDLE=2'd0, BUSY=2'd1, GAP=2'd2.
  - NUM_REQ=4.
- Sub-module rr_pick4: combinational; inputs req[3:0] and ptr[1:0]; outputs win[1:0] and any.
- Top holds the FSM, ptr, hold_cnt and output registers.

Test Plan:
- Reset: reset=1 for 2 cycles with req=1111 -> enable=0, addr=00, preempt=0. After release, the next edge gives enable=1, addr=00.
- Single requester: req=0100 -> next cycle enable=1, addr1=1, addr0=0, decoder out2 only. Hold 10 cycles, then req=0000 -> next cycle enable=0, then IDLE, addr stays 10.
- Timeout rotation, MAX_HOLD=4, req=1111 static:
  - Owners 0,1,2,3,0 in turn.
  - Each owner gets exactly 4 enable cycles, followed by 1 gap cycle.
  - preempt pulses in each gap cycle.
- Release ordering: owner 1 holds; req=1011; clear bit 1 -> after the gap, owner 3 (addr=11), not 0. Next release -> owner 0.
- Unlimited hold, MAX_HOLD=0: req=0011 for 100 cycles -> owner 0 throughout, preempt never 1. Drop bit 0 -> gap, then owner 1.
- Reset mid-grant: owner 2 active; assert reset for one edge -> enable=0 and addr=00 at that edge. After release with req=0100 -> owner 2 again one cycle later.
